// File: rtl/ram_stream_reader_if.sv
// Bundle of command, RAM and output-stream signals for ram_stream_reader.
// The master modport is the reader itself; slave is the surrounding system.
interface ram_stream_reader_if #(
  parameter int AW = 6,
  parameter int DW = 8
);
  logic          cmd_start;
  logic [AW-1:0] cmd_base;
  logic [AW:0]   cmd_len;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  logic          busy;
  logic          done;

  modport master (
    input  cmd_start, cmd_base, cmd_len, ram_q, m_ready,
    output ram_addr, ram_we, m_valid, m_data, m_last, busy, done
  );

  modport slave (
    output cmd_start, cmd_base, cmd_len, ram_q, m_ready,
    input  ram_addr, ram_we, m_valid, m_data, m_last, busy, done
  );
endinterface

// File: rtl/ram_stream_reader.sv
// Burst reader: fetches cmd_len bytes from a registered-address single-port RAM
// starting at cmd_base and streams them out through a 4-entry FIFO with valid/ready.
module ram_stream_reader #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  ram_stream_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [AW:0]   len_q, issued_q, remain_q;
  logic [AW-1:0] addr_q;
  logic          v1_q, v2_q;       // read pipeline: address registered / RAM data valid
  logic [DW-1:0] fifo_mem [4];
  logic [1:0]    wr_ptr_q, rd_ptr_q;
  logic [2:0]    count_q;
  logic          done_q;

  logic       accept, zero_cmd, issue, push, pop, last_xfer;
  logic [2:0] pending;

  // The first address is issued on the accepting edge so data reaches the FIFO two
  // edges later and m_valid rises in cycle 3.
  assign accept    = (state_q == IDLE) && bus.cmd_start && (bus.cmd_len != '0);
  assign zero_cmd  = (state_q == IDLE) && bus.cmd_start && (bus.cmd_len == '0);
  assign pending   = count_q + 3'(v1_q) + 3'(v2_q);
  assign issue     = (state_q == READ) && (issued_q != len_q) && (pending < 3'd4);
  assign push      = v2_q;
  assign pop       = bus.m_valid && bus.m_ready;
  assign last_xfer = pop && bus.m_last;

  assign bus.ram_addr = addr_q;
  assign bus.ram_we   = 1'b0;
  assign bus.m_valid  = (count_q != 3'd0);
  assign bus.m_data   = bus.m_valid ? fifo_mem[rd_ptr_q] : '0;
  assign bus.m_last   = bus.m_valid && (remain_q == (AW+1)'(1));
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    if (issued_q == len_q) state_d = DRAIN;
      DRAIN:   if (last_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      issued_q <= '0;
      remain_q <= '0;
      addr_q   <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= zero_cmd || ((state_q == DRAIN) && last_xfer);
      v1_q    <= accept || issue;
      v2_q    <= v1_q;

      if (accept) begin
        len_q    <= bus.cmd_len;
        remain_q <= bus.cmd_len;
        issued_q <= (AW+1)'(1);
        addr_q   <= bus.cmd_base;
      end else begin
        if (issue) begin
          issued_q <= issued_q + (AW+1)'(1);
          addr_q   <= addr_q + AW'(1);
        end
        if (pop) remain_q <= remain_q - (AW+1)'(1);
      end

      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the count and pointers define
  // which entries are live, and m_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.ram_q;
  end
endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: registered-address RAM model preloaded with
// mem[i]=i, stimulus driven and outputs sampled 1 time unit after each rising edge.
module tb_ram_stream_reader;
  localparam int AW = 6;
  localparam int DW = 8;
  localparam int BUDGET = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ram_stream_reader_if #(.AW(AW), .DW(DW)) bus ();
  ram_stream_reader #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) bus.ram_q <= mem[bus.ram_addr];

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] got_data [$];
  logic          got_last [$];
  int done_cnt, done_cyc, last_cyc, max_occ;
  bit timed_out;

  task automatic issue_cmd(input int base, input int len);
    bus.cmd_base  = AW'(base);
    bus.cmd_len   = (AW+1)'(len);
    bus.cmd_start = 1'b1;
    @(posedge clk); #1;
    bus.cmd_start = 1'b0;
  endtask

  // Runs from cycle 1 of a burst until n handshakes plus 4 trailing cycles.
  // mode 0: m_ready=1; mode 1: low for cycles 1..5 then toggling.
  task automatic collect(input int n, input int mode, input int inject, input int inj_base);
    int cyc = 1;
    int extra = -1;
    bit stalled = 0;
    logic [DW-1:0] held_data = '0;
    logic held_last = 1'b0;
    got_data.delete(); got_last.delete();
    done_cnt = 0; done_cyc = -1; last_cyc = -1; max_occ = 0; timed_out = 0;
    while (extra != 0) begin
      if (cyc >= BUDGET) begin timed_out = 1; break; end
      if (bus.done) begin done_cnt++; done_cyc = cyc; end
      if (int'(dut.count_q) > max_occ) max_occ = int'(dut.count_q);
      bus.cmd_start = (cyc == inject);
      if (cyc == inject) begin
        bus.cmd_base = AW'(inj_base);
        bus.cmd_len  = (AW+1)'(3);
      end
      if (extra >= 0 || mode == 0) bus.m_ready = 1'b1;
      else bus.m_ready = (cyc > 5) && (cyc % 2 == 0);
      if (stalled) begin
        vectors++;
        if ({bus.m_valid, bus.m_data, bus.m_last} !== {1'b1, held_data, held_last}) begin
          miscompares++;
          $display("FAIL stall_hold cyc=%0d got v=%b d=%0d l=%b want v=1 d=%0d l=%b",
                   cyc, bus.m_valid, bus.m_data, bus.m_last, held_data, held_last);
        end
      end
      stalled   = bus.m_valid && !bus.m_ready;
      held_data = bus.m_data;
      held_last = bus.m_last;
      if (bus.m_valid && bus.m_ready) begin
        got_data.push_back(bus.m_data);
        got_last.push_back(bus.m_last);
        if (got_data.size() == n) last_cyc = cyc;
      end
      if (extra > 0) extra--;
      if (got_data.size() == n && extra < 0) extra = 4;
      @(posedge clk); #1;
      cyc++;
    end
    bus.cmd_start = 1'b0;
  endtask

  task automatic check_burst(input string name, input logic [DW-1:0] exp_q [$]);
    vectors++;
    if (timed_out || got_data.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s_count got %0d bytes (timeout=%0b) want %0d",
               name, got_data.size(), timed_out, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
      vectors++;
      if (got_data[i] !== exp_q[i] || got_last[i] !== (i == exp_q.size() - 1)) begin
        miscompares++;
        $display("FAIL %s_byte%0d got d=%0d l=%b want d=%0d l=%b", name, i,
                 got_data[i], got_last[i], exp_q[i], (i == exp_q.size() - 1));
      end
    end
    vectors++;
    if (done_cnt != 1 || done_cyc != last_cyc + 1) begin
      miscompares++;
      $display("FAIL %s_done got %0d pulses at cyc %0d want 1 at cyc %0d",
               name, done_cnt, done_cyc, last_cyc + 1);
    end
    vectors++;
    if (max_occ > 4) begin
      miscompares++;
      $display("FAIL %s_occupancy got %0d want <=4", name, max_occ);
    end
  endtask

  task automatic test_reset;
    #2;
    vectors++;
    if ({bus.m_valid, bus.m_data, bus.m_last, bus.busy, bus.done, bus.ram_addr, bus.ram_we}
        !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got v=%b d=%0d l=%b busy=%b done=%b addr=%0d we=%b want all 0",
               bus.m_valid, bus.m_data, bus.m_last, bus.busy, bus.done, bus.ram_addr, bus.ram_we);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // base=0, len=8, m_ready=1: bytes in cycles 3..10, m_last in 10, done in 11.
  task automatic test_basic;
    logic [3:0] exp_ctl, got_ctl;
    bus.m_ready = 1'b1;
    issue_cmd(0, 8);
    for (int c = 1; c <= 12; c++) begin
      exp_ctl = {(c >= 3 && c <= 10), (c == 10), (c <= 10), (c == 11)};
      got_ctl = {bus.m_valid, bus.m_last, bus.busy, bus.done};
      vectors++;
      if (got_ctl !== exp_ctl) begin
        miscompares++;
        $display("FAIL basic_ctl cyc=%0d got v/l/busy/done=%b want %b", c, got_ctl, exp_ctl);
      end
      if (c >= 3 && c <= 10) begin
        vectors++;
        if (bus.m_data !== DW'(c - 3)) begin
          miscompares++;
          $display("FAIL basic_data cyc=%0d got %0d want %0d", c, bus.m_data, c - 3);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap;
    bus.m_ready = 1'b1;
    issue_cmd(62, 4);
    collect(4, 0, 0, 0);
    check_burst("wrap", '{8'd62, 8'd63, 8'd0, 8'd1});
  endtask

  task automatic test_backpressure;
    issue_cmd(5, 6);
    collect(6, 1, 0, 0);
    check_burst("bp", '{8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10});
  endtask

  task automatic test_len_zero;
    int pulses = 0;
    bit bad = 0;
    bus.m_ready = 1'b1;
    issue_cmd(9, 0);
    for (int c = 1; c <= 5; c++) begin
      if (bus.done) pulses++;
      if (bus.m_valid || bus.busy || (bus.done && c != 1)) bad = 1;
      @(posedge clk); #1;
    end
    vectors++;
    if (bad || pulses != 1) begin
      miscompares++;
      $display("FAIL len_zero got pulses=%0d bad=%0b want pulses=1 bad=0", pulses, bad);
    end
  endtask

  task automatic test_ignore_start;
    bus.m_ready = 1'b1;
    issue_cmd(20, 6);
    collect(6, 0, 2, 40);
    check_burst("ignore", '{8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25});
  endtask

  task automatic test_full_depth;
    logic [DW-1:0] exp_q [$];
    for (int i = 0; i < 2**AW; i++) exp_q.push_back(DW'((17 + i) % (2**AW)));
    bus.m_ready = 1'b1;
    issue_cmd(17, 2**AW);
    collect(2**AW, 0, 0, 0);
    check_burst("full", exp_q);
  endtask

  // Three bytes buffered at cycle 5 with m_ready low, then reset and a fresh burst.
  task automatic test_reset_mid;
    bus.m_ready = 1'b0;
    issue_cmd(30, 8);
    repeat (4) begin @(posedge clk); #1; end
    vectors++;
    if (dut.count_q !== 3'd3) begin
      miscompares++;
      $display("FAIL rmid_pending got %0d want 3", dut.count_q);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.m_valid, bus.m_data, bus.m_last, bus.busy, bus.done, bus.ram_addr} !== '0) begin
      miscompares++;
      $display("FAIL rmid_outputs got v=%b d=%0d l=%b busy=%b done=%b addr=%0d want all 0",
               bus.m_valid, bus.m_data, bus.m_last, bus.busy, bus.done, bus.ram_addr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.m_ready = 1'b1;
    issue_cmd(10, 2);
    collect(2, 0, 0, 0);
    check_burst("rmid", '{8'd10, 8'd11});
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = DW'(i);
    bus.cmd_start = 1'b0;
    bus.cmd_base  = '0;
    bus.cmd_len   = '0;
    bus.m_ready   = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len_zero();
    test_ignore_start();
    test_full_depth();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 Parameter AW, default 6: RAM address width; RAM depth is 2**AW.
REQ-002 Parameter DW, default 8: RAM data width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cmd_start  input  1  one-cycle request to begin a burst read; sampled only in IDLE.
REQ-006 cmd_base  input  AW  first RAM address of the burst.
REQ-007 cmd_len  input  AW+1  byte count, 0..2**AW; 0 means no-op.
REQ-008 ram_addr  output  AW  registered address to the single-port RAM.
REQ-009 ram_we  output  1  RAM write enable; constant 0.
REQ-010 ram_q  input  DW  RAM read data; valid one cycle after ram_addr is presented, because the RAM registers the address.
REQ-011 m_valid / m_ready  output / input  1 / 1  output stream handshake.
REQ-012 m_data  output  DW  stream data.
REQ-013 m_last  output  1  marks the final byte of the burst.
REQ-014 busy  output  1  high from the accepted cmd_start until the final handshake.
REQ-015 done  output  1  one-cycle pulse after the final handshake.

Function
REQ-016 FSM states: IDLE, READ, DRAIN; the block SHALL have no other reachable states.
REQ-017 IDLE: cmd_start=1 with cmd_len>0 SHALL latch base and len, go to READ, and set busy=1.
REQ-018 IDLE: cmd_start=1 with cmd_len=0 SHALL stay in IDLE, keep busy=0, and pulse done the next cycle.
REQ-019 cmd_start while busy SHALL be ignored, with no effect on the current burst.
REQ-020 Read issue (READ only): the block SHALL issue a read when (buffer occupancy + reads in flight) < 4.
REQ-021 Issuing a read SHALL load ram_addr with the next address; reads in flight are 0..2, issued but not yet captured.
REQ-022 Read data SHALL be captured from ram_q into a 4-entry FIFO exactly 2 edges after the address was registered.
REQ-023 Addresses SHALL increment modulo 2**AW, so base=62, len=4 reads 62, 63, 0, 1.
REQ-024 After len reads are issued, the FSM SHALL go to DRAIN.
REQ-025 DRAIN SHALL return to IDLE on the handshake of the byte with m_last=1.
REQ-026 m_valid SHALL equal (FIFO non-empty); m_data SHALL be the FIFO head; a transfer occurs when m_valid & m_ready.
REQ-027 m_valid, m_data, and m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-028 m_last SHALL be 1 only on byte number len of the burst.
REQ-029 done SHALL pulse 1 cycle after the last transfer, in the same cycle busy falls.
REQ-030 Latency: with cmd_start in cycle 0, m_valid SHALL first be 1 in cycle 3 with m_data=mem[base].
REQ-031 Throughput: with m_ready held 1, one byte SHALL transfer per cycle with no bubbles after the first.
REQ-032 Backpressure: the FIFO SHALL never overflow and no byte SHALL be dropped or duplicated for any m_ready pattern.
REQ-033 A push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-034 len=2**AW SHALL read every location once, starting at base.

Reset
REQ-035 rst_n=0 SHALL immediately force IDLE with ram_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0, the FIFO empty, and the in-flight count at 0.
REQ-036 Reset mid-burst SHALL abandon the burst; no stale RAM data SHALL appear on m_data after rst_n rises.
REQ-037 After rst_n rises, the first cmd_start SHALL be accepted on the first clock edge.

Verification
REQ-038 Preload mem[i]=i; base=0, len=8, m_ready=1 -> bytes 0..7 in cycles 3..10, m_last in cycle 10, done in cycle 11.
REQ-039 base=62, len=4 -> bytes 62, 63, 0, 1 with m_last on 1.
REQ-040 base=5, len=6, m_ready low 5 cycles then toggling every cycle -> exactly 5..10 in order, m_data stable while stalled, occupancy never exceeds 4.
REQ-041 len=0 -> no m_valid, busy stays 0, done pulses once.
REQ-042 cmd_start pulsed again mid-burst with a different base -> ignored; the original sequence completes.
REQ-043 rst_n asserted with 3 bytes pending -> all outputs 0 at once; a new base=10, len=2 burst then yields 10, 11 only.
